// File: rtl/iob_merge_rr_pkg.sv
// iob_merge_rr_pkg: FSM state encodings and grant-width helper shared by the merger and its arbiter
package iob_merge_rr_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    INV   = 2'd3
  } state_t;
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/iob_rr_arbiter.sv
// iob_rr_arbiter: combinational search for the first requester at or after ptr, wrapping to 0
module iob_rr_arbiter
  import iob_merge_rr_pkg::*;
#(
  parameter int N_MASTERS = 2,
  localparam int GW = grant_w(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [GW-1:0]        ptr,
  output logic [GW-1:0]        grant,
  output logic                 any
);
  function automatic logic [GW-1:0] wrap(input logic [GW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return GW'(s % N_MASTERS);
  endfunction
  // Scanning from the far end lets the nearest requester overwrite the rest.
  always_comb begin
    grant = '0;
    any = |req;
    for (int k = N_MASTERS - 1; k >= 0; k--)
      if (req[wrap(ptr, k)]) grant = wrap(ptr, k);
  end
endmodule

// File: rtl/iob_merge_rr.sv
// iob_merge_rr: N-master native-bus merger with round-robin grant and serialised L2 invalidation.
// Define IOB_MERGE_RR_FIXED_PRIO_EN for fixed lowest-index priority (no rotating pointer).
module iob_merge_rr
  import iob_merge_rr_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_MASTERS-1:0]           m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]    m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]    m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0]  m_wstrb,
  output logic [N_MASTERS*DATA_W-1:0]    m_rdata,
  output logic [N_MASTERS-1:0]           m_ready,
  output logic                           s_valid,
  output logic [ADDR_W-1:0]              s_addr,
  output logic [DATA_W-1:0]              s_wdata,
  output logic [DATA_W/8-1:0]            s_wstrb,
  input  logic [DATA_W-1:0]              s_rdata,
  input  logic                           s_ready,
  input  logic                           inv_req,
  input  logic                           wtb_empty,
  output logic                           s_force_inv,
  output logic                           inv_busy
);
  localparam int GW = grant_w(N_MASTERS);
  localparam int SW = DATA_W / 8;
  state_t state, state_n;
  logic [GW-1:0] grant, ptr, arb_grant;
  logic arb_any, inv_pend, busy;
  iob_rr_arbiter #(.N_MASTERS(N_MASTERS)) u_arb (
    .req  (m_valid),
    .ptr  (ptr),
    .grant(arb_grant),
    .any  (arb_any)
  );
  assign busy = state == BUSY;
  assign m_rdata = {N_MASTERS{s_rdata}};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      inv_pend <= 1'b0;
    end else begin
      state <= state_n;
      inv_pend <= inv_req | (inv_pend & (state != INV));
      if (state == IDLE && state_n == BUSY) grant <= arb_grant;
    end
`ifdef IOB_MERGE_RR_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (busy && s_ready) ptr <= (grant == GW'(N_MASTERS - 1)) ? '0 : grant + 1'b1;
`endif
  // A live inv_req counts as pending so invalidation wins the very next cycle.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (inv_pend | inv_req) ? DRAIN : arb_any ? BUSY : IDLE;
      BUSY:    state_n = (s_ready | ~m_valid[grant]) ? IDLE : BUSY;
      DRAIN:   state_n = wtb_empty ? INV : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    m_ready = '0;
    m_ready[grant] = busy & s_ready;
    s_valid = busy & m_valid[grant];
    s_addr = busy ? m_addr[grant*ADDR_W +: ADDR_W] : '0;
    s_wdata = busy ? m_wdata[grant*DATA_W +: DATA_W] : '0;
    s_wstrb = busy ? m_wstrb[grant*SW +: SW] : '0;
    s_force_inv = state == INV;
    inv_busy = inv_pend | (state == DRAIN) | (state == INV);
  end
endmodule
